datamem_banked: RTL and testbench
=================================

# datamem_banked

Parametrised banked data memory: the next generation of the accelerator's scratch data store. Generalises the fixed 8×64×16 banked memory to configurable data width, bank depth and bank count; adds a read-valid strobe, a hardware clear state machine that zeroes all banks after reset or on request, and optional write-first read-during-write forwarding. It sits between the MAC datapath and the load/store sequencer, with one write port and one read port on a single clock.

## Interface
- DATA_W, 16, data word width in bits
- BANK_AW, 6, per-bank address width; each bank holds 2^BANK_AW words
- BANK_SW, 3, bank-select width; NUM_BANKS = 2^BANK_SW
- ADDR_W, BANK_SW+BANK_AW (derived, not overridden), full address width; bank = addr[ADDR_W-1:BANK_AW], local = addr[BANK_AW-1:0]

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  request a full memory clear; honoured only when busy=0
- busy  out  1  high while the clear FSM runs; ports ignored while high
- wea  in  1  write enable
- waddr  in  ADDR_W  write address
- din  in  DATA_W  write data
- re  in  1  read enable
- raddr  in  ADDR_W  read address
- dout  out  DATA_W  registered read data; holds last value when no read completes
- dout_valid  out  1  one-cycle strobe, dout is new this cycle

## Operation
- FSM states: CLEAR, READY. rst_n low forces CLEAR with clear counter = 0.
- CLEAR: each cycle writes 0 to local address = counter in all NUM_BANKS banks in parallel; counter increments. At counter = 2^BANK_AW-1 the write occurs and the FSM moves to READY. Counter wraps to 0.
- READY: init_start=1 -> CLEAR, counter = 0. Otherwise stay.
- busy = 1 iff state == CLEAR.
- Write (READY, wea=1): only bank waddr[ADDR_W-1:BANK_AW] is written at local address; other banks untouched.
- Read (READY, re=1): every bank reads its local address; bank select registered alongside; output mux uses the registered select. dout and dout_valid update on the following edge.
- While busy: wea, re and init_start ignored; dout_valid = 0; dout holds.
- Memory arrays are not reset by rst_n; contents are defined only after the clear completes.
- Read and write in the same cycle to different addresses: both proceed independently.
- Same address, same cycle: see Configuration.
- Reset mid-clear: clear restarts from address 0 and runs the full 2^BANK_AW cycles.

## Timing
- Reset values: busy = 1, dout = 0, dout_valid = 0, state = CLEAR, counter = 0.
- Clear duration: exactly 2^BANK_AW cycles from the first edge after rst_n deassertion (64 at defaults); busy falls after the last clear write; first access is accepted in the first cycle busy = 0.
- init_start sampled at edge E (READY) -> busy = 1 after E; busy = 0 again 2^BANK_AW cycles later.
- Read latency: 1 cycle. re at edge E -> dout/dout_valid valid after E, until the next edge.
- Back-to-back reads every cycle are supported; dout_valid stays high throughout.
- Write latency: data is readable by a read issued on the cycle after the write (any configuration).

## Configuration
- DATAMEM_BYPASS_EN defined: write-first. Read and write to the same full address in the same READY cycle return din on dout.
- Undefined: read-first. The same collision returns the previously stored word; the new word is visible from the next read.
- No other behaviour differs.

## Test plan
- Reset then wait: busy = 1 for 64 cycles, then 0; reads of addresses 0, 63, 64, 511 return 0 with dout_valid pulsing one cycle after each re.
- Write 0x1234 @ 0x000, 0xBEEF @ 0x1FF, 0x0A0A @ 0x040; read back -> exact values; address 0x001 still 0 (no cross-bank or cross-word corruption).
- Same-cycle write 0x5555 @ 0x0C3 (old 0xAAAA) and read 0x0C3 -> 0x5555 with DATAMEM_BYPASS_EN, 0xAAAA without; next read 0x5555 in both.
- Fill memory, assert init_start: busy high 64 cycles; wea/re during busy ignored (dout_valid = 0, no write lands); afterwards all read 0.
- Assert rst_n low at clear cycle 30, release: busy stays high a full 64 cycles after release; dout = 0, dout_valid = 0 during reset.
- Streaming reads 0x000..0x1FF one per cycle against a reference model: dout_valid continuously high, every word matches, correct bank switched every 64 addresses.

Source files
------------

// File: rtl/datamem_banked.sv
`default_nettype none
// ============================================================================
// Module   : datamem_banked
// Purpose  : Parametrised banked scratch data memory with one write port and
//            one read port on a single clock. A clear state machine zeroes
//            every bank after reset or on request. While it runs, busy is
//            high and all port requests are ignored.
// Macro    : DATAMEM_BYPASS_EN
//            Defined: write-first forwarding on a same-address collision.
//            Undefined: read-first behaviour.
// Ports    : clk          - single clock, rising edge
//            rst_n        - asynchronous active-low reset
//            i_init_start - request a full clear (honoured when not busy)
//            o_busy       - high while the clear runs
//            i_wea/i_waddr/i_din - write port
//            i_re/i_raddr        - read port
//            o_dout       - read data, holds when no read completes
//            o_dout_valid - one-cycle strobe marking new o_dout
// Revision : 1.0 - initial release
// ============================================================================
module datamem_banked #(
  parameter  int DATA_W  = 16,
  parameter  int BANK_AW = 6,
  parameter  int BANK_SW = 3,
  localparam int ADDR_W  = BANK_SW + BANK_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init_start,
  output logic              o_busy,
  input  logic              i_wea,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_valid
);

  localparam int                 c_NUM_BANKS = 1 << BANK_SW;
  localparam int                 c_DEPTH     = 1 << BANK_AW;
  localparam logic [BANK_AW-1:0] c_CNT_LAST  = '1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BANK_AW-1:0]  r_clr_cnt;
  logic [BANK_AW-1:0]  w_clr_cnt_nxt;

  logic                w_clearing;
  logic                w_rd_fire;
  logic                w_wr_fire;
  logic                w_fwd;
  logic [BANK_SW-1:0]  w_wbank;
  logic [BANK_SW-1:0]  w_rbank;
  logic [BANK_AW-1:0]  w_wlocal;
  logic [BANK_AW-1:0]  w_rlocal;

  logic [BANK_SW-1:0]  r_rsel;
  logic                r_valid;
  logic [c_NUM_BANKS-1:0][DATA_W-1:0] w_bank_q;

  // --------------------------------------------------------------------------
  // Clear FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        // Counter wraps to 0 on the last clear write.
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == c_CNT_LAST) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (i_init_start) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Port decode
  // --------------------------------------------------------------------------
  assign w_clearing = (r_state == ST_CLEAR);
  assign w_rd_fire  = !w_clearing && i_re;
  assign w_wr_fire  = !w_clearing && i_wea;

  assign w_wbank  = i_waddr[ADDR_W-1:BANK_AW];
  assign w_wlocal = i_waddr[BANK_AW-1:0];
  assign w_rbank  = i_raddr[ADDR_W-1:BANK_AW];
  assign w_rlocal = i_raddr[BANK_AW-1:0];

`ifdef DATAMEM_BYPASS_EN
  // Same-address collision: the read captures the incoming write data.
  assign w_fwd = w_rd_fire && w_wr_fire && (i_waddr == i_raddr);
`else
  assign w_fwd = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Banks: the clear writes all banks in parallel, while a normal write hits
  // only the addressed bank. Every bank reads on each accepted read, and the
  // registered bank select picks the result.
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < c_NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [DATA_W-1:0]  r_q;
    logic               w_we;
    logic [BANK_AW-1:0] w_wa;
    logic [DATA_W-1:0]  w_wd;
    logic               w_rsel_hit;

    assign w_we       = w_clearing || (w_wr_fire && (w_wbank == BANK_SW'(b)));
    assign w_wa       = w_clearing ? r_clr_cnt : w_wlocal;
    assign w_wd       = w_clearing ? '0 : i_din;
    assign w_rsel_hit = (w_rbank == BANK_SW'(b));

    // Array contents carry no reset; they are defined once a clear completes.
    always_ff @(posedge clk) begin
      if (w_we) begin
        r_mem[w_wa] <= w_wd;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_rd_fire) begin
        r_q <= (w_fwd && w_rsel_hit) ? i_din : r_mem[w_rlocal];
      end
    end

    assign w_bank_q[b] = r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rsel  <= '0;
    end else begin
      r_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rsel <= w_rbank;
      end
    end
  end

  // All bank registers reset to zero, so o_dout is zero out of reset for any select.
  assign o_dout       = w_bank_q[r_rsel];
  assign o_dout_valid = r_valid;
  assign o_busy       = w_clearing;

endmodule
`default_nettype wire

// File: tb/tb_datamem_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamem_banked
// Purpose  : Scoreboard bench for datamem_banked at default parameters.
//            Reads push an expected word into a queue. A negedge monitor
//            pops that word and compares it whenever o_dout_valid is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamem_banked;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_start = 1'b0;
  logic        wea = 1'b0;
  logic        re = 1'b0;
  logic [8:0]  waddr = '0;
  logic [8:0]  raddr = '0;
  logic [15:0] din = '0;
  logic        busy;
  logic [15:0] dout;
  logic        dout_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries: {address, expected data}
  logic [24:0] exp_q [$];
  logic [24:0] mon_e;

  always #5 clk = ~clk;

  datamem_banked dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_init_start (init_start),
    .o_busy       (busy),
    .i_wea        (wea),
    .i_waddr      (waddr),
    .i_din        (din),
    .i_re         (re),
    .i_raddr      (raddr),
    .o_dout       (dout),
    .o_dout_valid (dout_valid)
  );

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 131 + 16'h1357);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    wea = 1'b1; waddr = a; din = d;
    tick;
    wea = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] d);
    re = 1'b1; raddr = a;
    exp_q.push_back({a, d});
    tick;
    re = 1'b0;
    check("rvalid", {31'd0, dout_valid}, 32'd1);
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick;
      n++;
    end
    check(nm, n, 32'd64);
  endtask

  // Monitor: compare every presented read against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got dout_valid=1 dout=%h expected no read", dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (dout !== mon_e[15:0]) begin
          n_fail++;
          $display("FAIL read@%h: got %h expected %h", mon_e[24:16], dout, mon_e[15:0]);
        end
      end
    end
  end

  initial begin
    int n;
    // ---- reset state and power-on clear ----
    repeat (3) tick;
    check("rst_busy",  {31'd0, busy}, 32'd1);
    check("rst_dout",  {16'd0, dout}, 32'd0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    rst_n = 1'b1;
    wait_ready("clear_len_por");

    rd(9'h000, 16'h0000);
    tick;
    check("valid_pulse", {31'd0, dout_valid}, 32'd0);
    rd(9'h03F, 16'h0000);
    rd(9'h040, 16'h0000);
    rd(9'h1FF, 16'h0000);
    tick;

    // ---- directed writes, no cross-bank/word corruption ----
    wr(9'h000, 16'h1234);
    wr(9'h1FF, 16'hBEEF);
    wr(9'h040, 16'h0A0A);
    rd(9'h000, 16'h1234);
    rd(9'h1FF, 16'hBEEF);
    rd(9'h040, 16'h0A0A);
    rd(9'h001, 16'h0000);
    rd(9'h03F, 16'h0000);

    // ---- read/write collision ----
    wr(9'h0C3, 16'hAAAA);
    wea = 1'b1; waddr = 9'h0C3; din = 16'h5555;
    re  = 1'b1; raddr = 9'h0C3;
`ifdef DATAMEM_BYPASS_EN
    exp_q.push_back({9'h0C3, 16'h5555});
`else
    exp_q.push_back({9'h0C3, 16'hAAAA});
`endif
    tick;
    wea = 1'b0; re = 1'b0;
    check("coll_valid", {31'd0, dout_valid}, 32'd1);
    rd(9'h0C3, 16'h5555);
    // different addresses in the same cycle
    wea = 1'b1; waddr = 9'h0C4; din = 16'h7777;
    re  = 1'b1; raddr = 9'h0C3;
    exp_q.push_back({9'h0C3, 16'h5555});
    tick;
    wea = 1'b0; re = 1'b0;
    rd(9'h0C4, 16'h7777);
    tick;

    // ---- fill, then stream all addresses ----
    for (int a = 0; a < 512; a++) wr(9'(a), pat(a));
    re = 1'b1;
    for (int a = 0; a < 512; a++) begin
      raddr = 9'(a);
      exp_q.push_back({9'(a), pat(a)});
      tick;
      check("stream_valid", {31'd0, dout_valid}, 32'd1);
    end
    re = 1'b0;
    tick;

    // ---- requested clear, ports ignored while busy ----
    rd(9'h155, pat(9'h155));
    init_start = 1'b1;
    tick;
    init_start = 1'b0;
    check("init_busy", {31'd0, busy}, 32'd1);
    wea = 1'b1; waddr = 9'h155; din = 16'hFFFF;
    re  = 1'b1; raddr = 9'h155;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      check("busy_nvalid", {31'd0, dout_valid}, 32'd0);
      check("busy_hold", {16'd0, dout}, {16'd0, pat(9'h155)});
      tick;
      n++;
    end
    wea = 1'b0; re = 1'b0;
    check("clear_len_init", n, 32'd64);
    rd(9'h155, 16'h0000);
    rd(9'h000, 16'h0000);
    rd(9'h1FF, 16'h0000);
    rd(9'h0C3, 16'h0000);

    // ---- reset in the middle of a clear ----
    wr(9'h0AB, 16'h4321);
    rd(9'h0AB, 16'h4321);
    init_start = 1'b1;
    tick;
    init_start = 1'b0;
    repeat (30) tick;
    rst_n = 1'b0;
    #2;
    check("midrst_busy",  {31'd0, busy}, 32'd1);
    check("midrst_dout",  {16'd0, dout}, 32'd0);
    check("midrst_valid", {31'd0, dout_valid}, 32'd0);
    repeat (2) tick;
    rst_n = 1'b1;
    wait_ready("clear_len_rst");
    rd(9'h0AB, 16'h0000);
    tick;

    // ---- drain scoreboard ----
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick;
      n++;
    end
    check("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
